// File: rtl/egg_timer_pkg.sv
// Egg timer shared types: FSM encoding, BCD time record,
// digit limits and BCD increment/decrement helpers.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 99;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t SEC_TENS_MAX = digit_t'(SEC_MAX / 10);
  localparam digit_t SEC_ONES_MAX = digit_t'(SEC_MAX % 10);
  localparam digit_t MIN_TENS_MAX = digit_t'(MIN_MAX / 10);
  localparam digit_t MIN_ONES_MAX = digit_t'(MIN_MAX % 10);

  typedef struct packed {
    digit_t min_tens;
    digit_t min_ones;
    digit_t sec_tens;
    digit_t sec_ones;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;
  localparam bcd_time_t TIME_ONE = '{
    min_tens: 4'd0,
    min_ones: 4'd0,
    sec_tens: 4'd0,
    sec_ones: 4'd1
  };

  function automatic bcd_time_t inc_min(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_ones >= MIN_ONES_MAX) begin
      r.min_ones = 4'd0;
      if (t.min_tens >= MIN_TENS_MAX)
        r.min_tens = 4'd0;
      else
        r.min_tens = t.min_tens + 4'd1;
    end else begin
      r.min_ones = t.min_ones + 4'd1;
    end
    return r;
  endfunction

  // Seconds wrap 59 -> 00 without touching minutes.
  function automatic bcd_time_t inc_sec(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones >= 4'd9) begin
      r.sec_ones = 4'd0;
      if (t.sec_tens >= SEC_TENS_MAX)
        r.sec_tens = 4'd0;
      else
        r.sec_tens = t.sec_tens + 4'd1;
    end else begin
      r.sec_ones = t.sec_ones + 4'd1;
    end
    return r;
  endfunction

  // One-second countdown with borrow; 00:00 is left alone.
  function automatic bcd_time_t dec_sec(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t == TIME_ZERO) begin
      r = TIME_ZERO;
    end else if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else if (t.sec_tens != 4'd0) begin
      r.sec_ones = 4'd9;
      r.sec_tens = t.sec_tens - 4'd1;
    end else begin
      r.sec_ones = SEC_ONES_MAX;
      r.sec_tens = SEC_TENS_MAX;
      if (t.min_ones != 4'd0) begin
        r.min_ones = t.min_ones - 4'd1;
      end else begin
        r.min_ones = 4'd9;
        r.min_tens = t.min_tens - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/egg_timer_ctrl_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while en, tick on wrap.
// Ports: clk, reset (sync), clr (to 0), en (count), tick (comb).
module one_sec_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: set MM:SS, count down, alarm, auto-return.
// Ports: clk, reset, btn_* pulses, BCD digits, running, alarm, state.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int AW =
    (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_SECS - 1);

  state_t           st_q, st_d;
  bcd_time_t        tm_q, tm_d;
  logic [AW-1:0]    alm_q, alm_d;
  logic             pre_clr;
  logic             pre_en;
  logic             tick;
  logic             counting;

  assign counting = (st_q == RUN) || (st_q == ALARM);

  // Kept independent of tick so the prescaler has no comb loop.
  // A start/clear edge freezes the count (pause holds its value).
  assign pre_en = counting && !btn_start && !btn_clear;

  assign pre_clr =
    btn_clear ||
    (btn_start && (st_q == ALARM)) ||
    (btn_start && (st_q == SETUP) && (tm_q != TIME_ZERO));

  one_sec_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_comb begin
    st_d  = st_q;
    tm_d  = tm_q;
    alm_d = alm_q;
    case (st_q)
      SETUP: begin
        if (btn_clear) begin
          tm_d = TIME_ZERO;
        end else if (btn_start) begin
          if (tm_q != TIME_ZERO)
            st_d = RUN;
        end else begin
          if (btn_min)
            tm_d = inc_min(tm_d);
          if (btn_sec)
            tm_d = inc_sec(tm_d);
        end
      end
      RUN: begin
        if (btn_clear) begin
          st_d = SETUP;
          tm_d = TIME_ZERO;
        end else if (btn_start) begin
          st_d = PAUSE;
        end else if (tick) begin
          if (tm_q == TIME_ONE) begin
            st_d  = ALARM;
            tm_d  = TIME_ZERO;
            alm_d = '0;
          end else begin
            tm_d = dec_sec(tm_q);
          end
        end
      end
      PAUSE: begin
        if (btn_clear) begin
          st_d = SETUP;
          tm_d = TIME_ZERO;
        end else if (btn_start) begin
          st_d = RUN;
        end
      end
      ALARM: begin
        tm_d = TIME_ZERO;
        if (btn_clear || btn_start) begin
          st_d  = SETUP;
          alm_d = '0;
        end else if (tick) begin
          // Prescaler wraps to 0 on this tick by itself.
          if (alm_q == ALM_LAST) begin
            st_d  = SETUP;
            alm_d = '0;
          end else begin
            alm_d = alm_q + AW'(1);
          end
        end
      end
      default: begin
        st_d  = SETUP;
        tm_d  = TIME_ZERO;
        alm_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= SETUP;
      tm_q    <= TIME_ZERO;
      alm_q   <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      st_q    <= st_d;
      tm_q    <= tm_d;
      alm_q   <= alm_d;
      running <= (st_d == RUN);
      alarm   <= (st_d == ALARM);
    end
  end

  assign state    = st_q;
  assign min_tens = tm_q.min_tens;
  assign min_ones = tm_q.min_ones;
  assign sec_tens = tm_q.sec_tens;
  assign sec_ones = tm_q.sec_ones;

endmodule
